// File: rtl/reg_dump_unit.sv
// Register-file debug dump: walks debug_reg_ra over [first_idx..last_idx] (wrapping) and streams samples out.
// Optional trailing XOR checksum beat when REG_DUMP_CHECKSUM_EN is defined.
module reg_dump_unit #(
  parameter int NREG   = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        first_idx,
  input  logic [4:0]        last_idx,
  output logic [4:0]        debug_reg_ra,
  input  logic [DATA_W-1:0] debug_reg_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [4:0] IDX_MAX = 5'(NREG - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SEND
`ifdef REG_DUMP_CHECKSUM_EN
    , S_CSUM
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [4:0]        cur_idx_q, cur_idx_d;
  logic [4:0]        last_q, last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [4:0]        out_idx_q, out_idx_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;
  logic [4:0]        nxt_idx;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              reg_fin_q, reg_fin_d;  // current beat is the final register word
`endif

  assign nxt_idx = (cur_idx_q == IDX_MAX) ? 5'd0 : cur_idx_q + 5'd1;

  always_comb begin
    state_d     = state_q;
    cur_idx_d   = cur_idx_q;
    last_d      = last_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d      = csum_q;
    reg_fin_d   = reg_fin_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          last_d    = last_idx;
          cur_idx_d = first_idx;
          state_d   = S_READ;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end
      S_READ: begin
        // debug_reg_ra has been driven from cur_idx_q for this whole cycle
        out_data_d  = debug_reg_rd;
        out_idx_d   = cur_idx_q;
        out_valid_d = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
        reg_fin_d   = (cur_idx_q == last_q);
`else
        out_last_d  = (cur_idx_q == last_q);
`endif
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            out_last_d = 1'b0;
            done_d     = 1'b1;
            state_d    = S_IDLE;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            csum_d = csum_q ^ out_data_q;
            if (reg_fin_q) begin
              state_d = S_CSUM;
            end else begin
              cur_idx_d = nxt_idx;
              state_d   = S_READ;
            end
`else
            cur_idx_d = nxt_idx;
            state_d   = S_READ;
`endif
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      S_CSUM: begin
        out_data_d  = csum_q;
        out_idx_d   = 5'd0;
        out_last_d  = 1'b1;
        out_valid_d = 1'b1;
        reg_fin_d   = 1'b0;
        state_d     = S_SEND;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_idx_q   <= '0;
      last_q      <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q      <= '0;
      reg_fin_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cur_idx_q   <= cur_idx_d;
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q      <= csum_d;
      reg_fin_q   <= reg_fin_d;
`endif
    end
  end

  assign debug_reg_ra = cur_idx_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_idx      = out_idx_q;
  assign out_last     = out_last_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit: behavioural register file, beat-by-beat checks against a small model.
module tb_reg_dump_unit;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  first_idx = '0, last_idx = '0;
  logic [4:0]  debug_reg_ra;
  logic [31:0] debug_reg_rd;
  logic        out_valid, out_ready = 1'b0, out_last, busy, done;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic [31:0] rf [32];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  assign debug_reg_rd = rf[debug_reg_ra];

  reg_dump_unit #(.NREG(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .first_idx(first_idx), .last_idx(last_idx),
    .debug_reg_ra(debug_reg_ra), .debug_reg_rd(debug_reg_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // mode 0: out_ready always high; mode 1: out_ready high one cycle in three
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode);
    int n, nb, k, cyc, lat;
    logic [4:0]  ei, pi, span;
    logic [31:0] ed, pd, x;
    logic        el, stall, fin;
    span = l - f;
    n = int'(span) + 1;
    nb = n + CS;
    k = 0; lat = -1; x = '0; stall = 1'b0; fin = 1'b0;
    pd = '0; pi = '0;
    @(negedge clk);
    first_idx = f; last_idx = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!fin && cyc < 400) begin
      if (out_valid && lat < 0) begin
        lat = cyc;
        chk("first_valid_latency", lat, 2);
      end
      chk("busy", {31'b0, busy}, 1);
      if (stall && out_valid) begin
        chk("stall_data", out_data, pd);
        chk("stall_idx", {27'b0, out_idx}, {27'b0, pi});
      end
      out_ready = (mode == 0) || (cyc % 3 == 0);
      if (out_valid) begin
        if (k < n) begin
          ei = 5'(int'(f) + k);
          ed = rf[ei];
          el = (k == n - 1) && (CS == 0);
        end else begin
          ei = 5'd0;
          ed = x;
          el = 1'b1;
        end
        if (out_ready) begin
          chk("beat_idx", {27'b0, out_idx}, {27'b0, ei});
          chk("beat_data", out_data, ed);
          chk("beat_last", {31'b0, out_last}, {31'b0, el});
          if (k < n) x = x ^ rf[ei];
          k++;
          if (k == nb) fin = 1'b1;
        end
        stall = !out_ready;
        pd = out_data;
        pi = out_idx;
      end else begin
        stall = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    chk("beat_count", k, nb);
    chk("done_pulse", {31'b0, done}, 1);
    chk("busy_at_done", {31'b0, busy}, 0);
    chk("valid_after", {31'b0, out_valid}, 0);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 0);
  endtask

  initial begin
    bit pulsed, seen4, hit10;
    for (int i = 0; i < 32; i++) rf[i] = 32'hA500_0000 | (i * 32'h0001_0101);
    rf[0]  = 32'h0;
    rf[1]  = 32'd1;
    rf[5]  = 32'h1234_5678;
    rf[6]  = 32'hDEAD_BEEF;
    rf[30] = 32'd30;
    rf[31] = 32'd31;

    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ra", {27'b0, debug_reg_ra}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_dump(5'd5, 5'd6, 0);
    run_dump(5'd0, 5'd0, 0);
    run_dump(5'd30, 5'd1, 0);
    run_dump(5'd0, 5'd31, 1);

    // restart attempt mid-dump, then asynchronous reset at idx 10
    pulsed = 0; seen4 = 0; hit10 = 0;
    @(negedge clk);
    first_idx = 5'd0; last_idx = 5'd31; start = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 200 && !hit10; c++) begin
      start = 1'b0;
      if (out_valid && out_idx == 5'd3 && !pulsed) begin
        pulsed = 1;
        start = 1'b1;
        first_idx = 5'd20;
      end
      if (out_valid && out_idx == 5'd4 && pulsed) seen4 = 1;
      if (out_valid && out_idx == 5'd10) hit10 = 1;
      else @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b0;
    chk("restart_ignored", {31'b0, seen4}, 1);
    chk("reached_idx10", {31'b0, hit10}, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 0);
    chk("arst_data", out_data, 0);
    chk("arst_idx", {27'b0, out_idx}, 0);
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_ra", {27'b0, debug_reg_ra}, 0);
    repeat (2) @(negedge clk);
    chk("arst_no_done", {31'b0, done}, 0);
    rst = 1'b0;
    run_dump(5'd7, 5'd8, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
